// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared types and constants for the memory responder
//
// Purpose: width typedefs, the sequencer state encoding and the beat geometry
// used by mem_responder and mem_array.
package mem_responder_pkg;

  typedef logic [3:0]  ulogic4;
  typedef logic [15:0] ulogic16;
  typedef logic [63:0] ulogic64;

  localparam int BEATS    = 4;
  localparam int BEAT_W   = 16;
  localparam int PAGE_W   = 4;
  localparam int OFFSET_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    WR_BEAT,
    RD_WAIT,
    RD_BEAT
  } mem_state_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// rtl/mem_responder_mem_array.sv - DEPTH x 64 synchronous single-port word store
//
// Purpose: storage for the responder, kept apart from the beat sequencer.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable; wdata stored at addr on the edge
//   addr   in   word index (shared by read and write)
//   wdata  in   64-bit write word
//   rdata  out  64-bit word registered from mem[addr] (value before a same-edge write)
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  ulogic64       wdata,
  output ulogic64       rdata
);

  ulogic64 mem [DEPTH];
  ulogic64 rdata_q;

  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - bus-side memory responder, 64-bit words over 4 x 16-bit beats
//
// Purpose: answers address cycles whose page matches PAGE, taking 4 write beats
// into a shadow word or returning 4 read beats RD_LAT idle cycles after the
// address cycle. Optional address-range checking under `MEM_ECHK_EN`.
// Ports:
//   clk        in   clock, rising edge
//   resetH     in   synchronous active-high reset
//   AddrValid  in   qualifies Address/rw for one cycle
//   rw         in   1 = read, 0 = write
//   Address    in   [15:12] page, [11:0] word offset
//   DataIn     in   write beat data
//   DataOut    out  read beat data, 0 when DataOE is low
//   DataOE     out  high while DataOut carries a read beat
//   Busy       out  high from the cycle after accept until the last beat
//   Err        out  out-of-range pulse (MEM_ECHK_EN only, else constant 0)
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter ulogic4 PAGE   = 4'h2,
  parameter int     DEPTH  = 256,
  parameter int     RD_LAT = 2
) (
  input  logic    clk,
  input  logic    resetH,
  input  logic    AddrValid,
  input  logic    rw,
  input  ulogic16 Address,
  input  ulogic16 DataIn,
  output ulogic16 DataOut,
  output logic    DataOE,
  output logic    Busy,
  output logic    Err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_state_t       state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [1:0]       beat_q, beat_d;
  logic [2:0]       lat_q, lat_d;
  ulogic64          shadow_q, shadow_d;
  logic             err_q, err_d;
  logic             oor_q, oor_d;

  logic             accept;
  logic             addr_oor;
  logic [IDX_W-1:0] addr_idx;
  logic             mem_we;
  logic [IDX_W-1:0] mem_addr;
  ulogic64          mem_wdata;
  ulogic64          mem_rdata;

  assign addr_idx = Address[IDX_W-1:0];
  assign accept   = (state_q == IDLE) && AddrValid
                    && (Address[OFFSET_W +: PAGE_W] == PAGE);

`ifdef MEM_ECHK_EN
  assign addr_oor = ({1'b0, Address[OFFSET_W-1:0]} >= (OFFSET_W+1)'(DEPTH));
`else
  // Offset simply wraps modulo DEPTH; the upper offset bits are don't-care.
  logic unused_offset;
  assign unused_offset = ^Address[OFFSET_W-1:0];
  assign addr_oor      = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    shadow_d  = shadow_q;
    oor_d     = oor_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    // Last beat goes straight into the store alongside the three captured ones.
    mem_wdata = {DataIn, shadow_q[3*BEAT_W-1:0]};
    // While idle the store is addressed from the bus so a read's word is
    // ready in the first RD_WAIT cycle.
    mem_addr  = (state_q == IDLE) ? addr_idx : index_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          index_d = addr_idx;
          oor_d   = addr_oor;
          err_d   = addr_oor;
          beat_d  = 2'd0;
          lat_d   = 3'd0;
          state_d = rw ? RD_WAIT : WR_BEAT;
        end
      end
      WR_BEAT: begin
        shadow_d[BEAT_W*beat_q +: BEAT_W] = DataIn;
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'(BEATS-1)) begin
          mem_we  = !oor_q;
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (lat_q == 3'd0) begin
          shadow_d = oor_q ? 64'h0 : mem_rdata;
        end
        if (lat_q == 3'(RD_LAT-1)) begin
          lat_d   = 3'd0;
          state_d = RD_BEAT;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      RD_BEAT: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'(BEATS-1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetH) begin
      state_q  <= IDLE;
      index_q  <= '0;
      beat_q   <= 2'd0;
      lat_q    <= 3'd0;
      shadow_q <= '0;
      err_q    <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      beat_q   <= beat_d;
      lat_q    <= lat_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      oor_q    <= oor_d;
    end
  end

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (IDX_W)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign DataOE  = (state_q == RD_BEAT);
  assign DataOut = DataOE ? shadow_q[BEAT_W*beat_q +: BEAT_W] : 16'h0;
  assign Busy    = (state_q != IDLE);
  assign Err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
module tb_mem_responder;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        resetH;
  logic        AddrValid;
  logic        rw;
  logic [15:0] Address;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        DataOE;
  logic        Busy;
  logic        Err;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  mem_responder #(
    .PAGE   (4'h2),
    .DEPTH  (256),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .resetH    (resetH),
    .AddrValid (AddrValid),
    .rw        (rw),
    .Address   (Address),
    .DataIn    (DataIn),
    .DataOut   (DataOut),
    .DataOE    (DataOE),
    .Busy      (Busy),
    .Err       (Err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every read beat must match the next queued value.
  always @(negedge clk) begin
    if (!resetH) begin
      if (DataOE) begin
        if (exp_q.size() == 0) check("extra_beat", 64'd1, 64'd0);
        else check("beat", {48'h0, DataOut}, {48'h0, exp_q.pop_front()});
      end else if (DataOut != 16'h0) begin
        check("idle_dataout", {48'h0, DataOut}, 64'h0);
      end
    end
  end

  task automatic do_write(input logic [3:0] pg, input logic [11:0] a,
                          input logic [63:0] d, input logic exp_busy);
    @(negedge clk);
    AddrValid = 1'b1; rw = 1'b0; Address = {pg, a};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      AddrValid = 1'b0;
      DataIn = d[16*k +: 16];
      check("wr_busy", {63'h0, Busy}, {63'h0, exp_busy});
    end
  endtask

  task automatic do_read(input logic [3:0] pg, input logic [11:0] a,
                         input logic [63:0] d, input logic exp_err);
    int n;
    @(negedge clk);
    AddrValid = 1'b1; rw = 1'b1; Address = {pg, a};
    for (int k = 0; k < 4; k++) exp_q.push_back(d[16*k +: 16]);
    @(negedge clk);
    AddrValid = 1'b0;
    n = 1;
    check("busy_rise", {63'h0, Busy}, 64'd1);
    check("err_pulse", {63'h0, Err}, {63'h0, exp_err});
    while (!DataOE && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 2) check("err_clear", {63'h0, Err}, 64'd0);
    end
    check("rd_latency", 64'(n), 64'(RD_LAT + 1));
    repeat (4) @(negedge clk);
    check("busy_fall", {63'h0, Busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    resetH = 1'b1; AddrValid = 1'b0; rw = 1'b0; Address = 16'h0; DataIn = 16'h0;
    repeat (3) @(negedge clk);
    resetH = 1'b0;
    check("rst_busy", {63'h0, Busy}, 64'd0);
    check("rst_oe", {63'h0, DataOE}, 64'd0);
    check("rst_dout", {48'h0, DataOut}, 64'd0);
    check("rst_err", {63'h0, Err}, 64'd0);

    // 1: basic write/read
    do_write(4'h2, 12'd32, 64'd128, 1'b1);
    do_read(4'h2, 12'd32, 64'd128, 1'b0);

    // 2: foreign page is ignored
    do_write(4'h2, 12'd5, 64'h1111_2222_3333_4444, 1'b1);
    do_write(4'h3, 12'd5, 64'h5555_6666_7777_8888, 1'b0);
    @(negedge clk);
    check("page_busy", {63'h0, Busy}, 64'd0);
    do_read(4'h2, 12'd5, 64'h1111_2222_3333_4444, 1'b0);

    // 3: back-to-back write then read
    do_write(4'h2, 12'd7, 64'hDEAD_BEEF_0123_4567, 1'b1);
    do_read(4'h2, 12'd7, 64'hDEAD_BEEF_0123_4567, 1'b0);

    // 4: AddrValid mid-burst must not start another transfer
    @(negedge clk);
    AddrValid = 1'b1; rw = 1'b0; Address = {4'h2, 12'd10};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      AddrValid = (k == 1);
      rw = 1'b1;
      Address = {4'h2, 12'd32};
      DataIn = 16'hA000 + 16'(k);
    end
    @(negedge clk);
    AddrValid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("ignored_busy", {63'h0, Busy}, 64'd0);
    end
    do_read(4'h2, 12'd10, 64'hA003_A002_A001_A000, 1'b0);
    do_read(4'h2, 12'd32, 64'd128, 1'b0);

    // 5: reset during a write leaves the word unchanged
    do_write(4'h2, 12'd9, 64'h1, 1'b1);
    @(negedge clk);
    AddrValid = 1'b1; rw = 1'b0; Address = {4'h2, 12'd9};
    @(negedge clk); AddrValid = 1'b0; DataIn = 16'hFFFF;
    @(negedge clk); DataIn = 16'hFFFF;
    @(negedge clk); DataIn = 16'hFFFF; resetH = 1'b1;
    @(negedge clk); resetH = 1'b0;
    check("rst_mid_busy", {63'h0, Busy}, 64'd0);
    do_read(4'h2, 12'd9, 64'h1, 1'b0);

    // 6: out-of-range offset
`ifdef MEM_ECHK_EN
    do_read(4'h2, 12'd300, 64'h0, 1'b1);
`else
    do_write(4'h2, 12'd44, 64'hCAFE_F00D_1234_ABCD, 1'b1);
    do_read(4'h2, 12'd300, 64'hCAFE_F00D_1234_ABCD, 1'b0);
`endif

    repeat (5) @(negedge clk);
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
